regfile_sb: RTL and testbench

- Parametrised successor to the ID-stage register file.
- Generalised storage with NUM_RD combinational read ports and one synchronous write port.
- Adds write-to-read bypass and a per-register pending-write scoreboard (saturating in-flight counters), so the hazard unit can stall on RAW without comparing pipeline-stage destinations.
- Sits in ID; written from WB; issue-marked from ID when an instruction with WB_EN leaves ID.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/sb_counter.sv | 37 +++
 rtl/regfile_sb.sv | 88 ++++++++
 tb/tb_regfile_sb.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults, types and reset-value helper for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_REGS = 15;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  function automatic reg_data_t init_val(input int unsigned i, input bit init_index);
    return init_index ? reg_data_t'(i) : '0;
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Saturating in-flight write counter for one register; inc is refused while
// saturated unless a same-cycle dec frees the slot.
module sb_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic flush,
  output logic full,
  output logic nonzero,
  output logic one
);

  logic [CNT_W-1:0] cnt;
  logic             inc_ok;
  logic             dec_ok;

  assign full    = (cnt == '1);
  assign nonzero = (cnt != '0);
  assign one     = (cnt == CNT_W'(1));
  assign inc_ok  = inc & (~full | dec);
  assign dec_ok  = dec & nonzero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (flush)
      cnt <= '0;
    else if (inc_ok && !dec_ok)
      cnt <= cnt + CNT_W'(1);
    else if (dec_ok && !inc_ok)
      cnt <= cnt - CNT_W'(1);
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with NUM_RD bypassed read ports and a pending-write scoreboard.
module regfile_sb #(
  parameter int unsigned DATA_W     = regfile_pkg::DATA_W,
  parameter int unsigned NUM_REGS   = regfile_pkg::NUM_REGS,
  parameter int unsigned ADDR_W     = regfile_pkg::ADDR_W,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned CNT_W      = 2,
  parameter int unsigned INIT_INDEX = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     issue_full,
  input  logic                     flush
);

  import regfile_pkg::*;

  localparam int unsigned SPAN = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wb_hit;
  logic              issue_in_range;
  logic [SPAN-1:0]   cnt_full;
  logic [SPAN-1:0]   cnt_nz;
  logic [SPAN-1:0]   cnt_one;

  assign wb_hit         = wb_en && (32'(wb_addr) < NUM_REGS);
  assign issue_in_range = 32'(issue_addr) < NUM_REGS;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        regs[i] <= DATA_W'(init_val(i, INIT_INDEX != 0));
    end else if (wb_hit) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Status vectors span the whole address space so any address can index them;
  // slots beyond NUM_REGS read as idle.
  for (genvar r = 0; r < SPAN; r++) begin : g_sb
    if (r < NUM_REGS) begin : g_cnt
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (issue_en && (issue_addr == ADDR_W'(r))),
        .dec     (wb_en && (wb_addr == ADDR_W'(r))),
        .flush   (flush),
        .full    (cnt_full[r]),
        .nonzero (cnt_nz[r]),
        .one     (cnt_one[r])
      );
    end else begin : g_tie
      assign cnt_full[r] = 1'b0;
      assign cnt_nz[r]   = 1'b0;
      assign cnt_one[r]  = 1'b0;
    end
  end

  assign issue_full = issue_in_range && cnt_full[issue_addr] &&
                      !(wb_en && (wb_addr == issue_addr));

  always_comb begin
    logic [ADDR_W-1:0] a;
    logic              wb_match;
    rd_data  = '0;
    rd_busy  = '0;
    a        = '0;
    wb_match = 1'b0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      a        = rd_addr[p*ADDR_W +: ADDR_W];
      wb_match = wb_en && (wb_addr == a);
      if (32'(a) < NUM_REGS) begin
        rd_data[p*DATA_W +: DATA_W] = wb_match ? wb_data : regs[a];
        rd_busy[p] = cnt_nz[a] && !(wb_match && cnt_one[a]);
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, async reset checks,
// and randomized traffic compared against a behavioural scoreboard model.
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [7:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        issue_en;
  logic [3:0]  issue_addr;
  logic        issue_full;
  logic        flush;

  int n_cmp;
  int n_bad;

  // Reference state: architectural values and number of writes in flight.
  logic [31:0] m_reg [15];
  int          m_cnt [15];

  regfile_sb #(
    .DATA_W(32), .NUM_REGS(15), .ADDR_W(4), .NUM_RD(2), .CNT_W(2), .INIT_INDEX(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .issue_full (issue_full),
    .flush      (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic [3:0]  rd0;
    logic [3:0]  rd1;
    logic        iss_en;
    logic [3:0]  iss_addr;
    logic        flush;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic [1:0]  e_busy;
    logic        e_full;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input int a);
    if (a >= 15) return 32'd0;
    if (wb_en && int'(wb_addr) == a) return wb_data;
    return m_reg[a];
  endfunction

  function automatic logic m_busy(input int a);
    if (a >= 15) return 1'b0;
    return (m_cnt[a] != 0) && !(wb_en && int'(wb_addr) == a && m_cnt[a] == 1);
  endfunction

  function automatic logic m_full();
    int a;
    a = int'(issue_addr);
    if (a >= 15) return 1'b0;
    return (m_cnt[a] == 3) && !(wb_en && wb_addr == issue_addr);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) begin
      m_reg[i] = 32'(i);
      m_cnt[i] = 0;
    end
  endtask

  // Evaluate next model state from current inputs, take the edge, then commit.
  task automatic advance();
    logic [31:0] nreg [15];
    int          ncnt [15];
    logic        full_now;
    full_now = m_full();
    for (int r = 0; r < 15; r++) begin
      nreg[r] = m_reg[r];
      ncnt[r] = m_cnt[r];
      if (wb_en && int'(wb_addr) == r) nreg[r] = wb_data;
      if (flush) ncnt[r] = 0;
      else begin
        if (issue_en && int'(issue_addr) == r && !full_now) ncnt[r] = ncnt[r] + 1;
        if (wb_en && int'(wb_addr) == r && m_cnt[r] != 0)   ncnt[r] = ncnt[r] - 1;
      end
    end
    @(posedge clk);
    for (int r = 0; r < 15; r++) begin
      m_reg[r] = nreg[r];
      m_cnt[r] = ncnt[r];
    end
    #1;
  endtask

  task automatic idle_inputs();
    wb_en = 0; wb_addr = 0; wb_data = 0; rd_addr = 0;
    issue_en = 0; issue_addr = 0; flush = 0;
  endtask

  // Raise rst between edges and check the outputs change without a clock.
  task automatic async_reset(input string tag);
    idle_inputs();
    rd_addr    = {4'd7, 4'd3};
    issue_addr = 4'd7;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check({tag, "_rd_data"}, rd_data, {32'd7, 32'd3});
    check({tag, "_rd_busy"}, {62'd0, rd_busy}, 64'd0);
    check({tag, "_issue_full"}, {63'd0, issue_full}, 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_rd_data"}, rd_data, {m_read(int'(rd_addr[7:4])), m_read(int'(rd_addr[3:0]))});
    check({tag, "_rd_busy"}, {62'd0, rd_busy},
          {62'd0, m_busy(int'(rd_addr[7:4])), m_busy(int'(rd_addr[3:0]))});
    check({tag, "_issue_full"}, {63'd0, issue_full}, {63'd0, m_full()});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    idle_inputs();
    model_reset();

    //          wb  addr  data          rd0 rd1 iss iaddr fl  e_d0          e_d1         busy  full
    vecs[0]  = '{1, 5, 32'hDEADBEEF,     5,  6,  0,  0,   0, 32'hDEADBEEF, 32'd6,       2'b00, 0};
    vecs[1]  = '{0, 0, 32'h0,            5,  5,  0,  0,   0, 32'hDEADBEEF, 32'hDEADBEEF,2'b00, 0};
    vecs[2]  = '{0, 0, 32'h0,            2,  0,  1,  2,   0, 32'd2,        32'd0,       2'b00, 0};
    vecs[3]  = '{0, 0, 32'h0,            2,  0,  1,  2,   0, 32'd2,        32'd0,       2'b01, 0};
    vecs[4]  = '{0, 0, 32'h0,            2,  0,  1,  2,   0, 32'd2,        32'd0,       2'b01, 0};
    vecs[5]  = '{0, 0, 32'h0,            2,  0,  1,  2,   0, 32'd2,        32'd0,       2'b01, 1};
    vecs[6]  = '{1, 2, 32'h22,           2,  0,  1,  2,   0, 32'h22,       32'd0,       2'b01, 0};
    vecs[7]  = '{0, 0, 32'h0,            2,  0,  0,  2,   0, 32'h22,       32'd0,       2'b01, 1};
    vecs[8]  = '{0, 0, 32'h0,            4,  2,  1,  4,   0, 32'd4,        32'h22,      2'b10, 0};
    vecs[9]  = '{1, 4, 32'h1234,         4,  2,  0,  4,   0, 32'h1234,     32'h22,      2'b10, 0};
    vecs[10] = '{0, 0, 32'h0,            4,  4,  0,  4,   0, 32'h1234,     32'h1234,    2'b00, 0};
    vecs[11] = '{0, 0, 32'h0,            1,  9,  1,  1,   0, 32'd1,        32'd9,       2'b00, 0};
    vecs[12] = '{0, 0, 32'h0,            1,  9,  1,  1,   0, 32'd1,        32'd9,       2'b01, 0};
    vecs[13] = '{0, 0, 32'h0,            1,  9,  1,  9,   0, 32'd1,        32'd9,       2'b01, 0};
    vecs[14] = '{1, 3, 32'd77,           1,  9,  1,  9,   1, 32'd1,        32'd9,       2'b11, 0};
    vecs[15] = '{0, 0, 32'h0,            3,  9,  0,  2,   0, 32'd77,       32'd9,       2'b00, 0};
    vecs[16] = '{0, 0, 32'h0,            1,  2,  0,  9,   0, 32'd1,        32'h22,      2'b00, 0};
    vecs[17] = '{1, 15, 32'hFFFFFFFF,   15, 14,  1, 15,   0, 32'd0,        32'd14,      2'b00, 0};
    vecs[18] = '{0, 0, 32'h0,           14,  0,  0,  0,   0, 32'd14,       32'd0,       2'b00, 0};

    #2;
    rst = 1'b0;
    #1;

    for (int i = 0; i < 19; i++) begin
      wb_en      = vecs[i].wb_en;
      wb_addr    = vecs[i].wb_addr;
      wb_data    = vecs[i].wb_data;
      rd_addr    = {vecs[i].rd1, vecs[i].rd0};
      issue_en   = vecs[i].iss_en;
      issue_addr = vecs[i].iss_addr;
      flush      = vecs[i].flush;
      #1;
      check($sformatf("vec%0d_rd_data", i), rd_data, {vecs[i].e_d1, vecs[i].e_d0});
      check($sformatf("vec%0d_rd_busy", i), {62'd0, rd_busy}, {62'd0, vecs[i].e_busy});
      check($sformatf("vec%0d_issue_full", i), {63'd0, issue_full}, {63'd0, vecs[i].e_full});
      advance();
    end

    // Dirty reg 3 and scoreboard entry 7, then reset asynchronously.
    idle_inputs();
    wb_en = 1; wb_addr = 3; wb_data = 32'h55;
    issue_en = 1; issue_addr = 7;
    advance();
    idle_inputs();
    rd_addr = {4'd7, 4'd3};
    #1;
    check("pre_reset_rd_data", rd_data, {32'd7, 32'h55});
    check("pre_reset_rd_busy", {62'd0, rd_busy}, {62'd0, 2'b10});
    async_reset("async_reset");

    for (int k = 0; k < 800; k++) begin
      if (k == 400) async_reset("mid_reset");
      wb_en      = ($urandom_range(0, 1) == 1);
      wb_addr    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      wb_data    = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
      rd_addr    = {4'($urandom_range(0, 4)), 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 2) == 0) rd_addr[7:4] = wb_addr;
      issue_en   = ($urandom_range(0, 9) < 6);
      issue_addr = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      flush      = ($urandom_range(0, 29) == 0);
      #1;
      check_model($sformatf("rand%0d", k));
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
